// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: access size encodings,
// FSM state type and the request legality rule.
package mem_access_unit_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_t;

    // Illegal size, or a half/word access not naturally aligned.
    function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] offset);
        return (size == 2'b11) ||
               ((size == SIZE_H) && offset[0]) ||
               ((size == SIZE_W) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Little-endian lane handling: extracts and extends the addressed byte/half
// of a read word, and merges store data into the addressed lane of a word.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] base_word,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select, extension and merge for the addressed lane.
    always_comb begin
        byte_sel   = rd_word[{offset, 3'b000} +: 8];
        half_sel   = offset[1] ? rd_word[31:16] : rd_word[15:0];
        load_data  = rd_word;
        merge_data = base_word;
        case (size)
            SIZE_B: begin
                load_data = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                merge_data[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_H: begin
                load_data = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
                if (offset[1]) merge_data[31:16] = wdata[15:0];
                else           merge_data[15:0]  = wdata[15:0];
            end
            default: begin
                load_data  = rd_word;
                merge_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: accepts one byte/half/word request at a time, performs
// read-modify-write for sub-word stores and returns a single response.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [17:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [15:0] mem_address,
    output logic        mem_write_en,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    state_t      state, state_nxt;
    logic        r_write;
    logic        r_unsigned;
    logic [1:0]  r_size;
    logic [17:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] word_q;
    logic [31:0] load_data;
    logic [31:0] merge_data;
    logic        accept;
    logic        req_err;

    assign req_ready      = (state == IDLE);
    assign accept         = req_valid && req_ready;
    assign req_err        = req_is_bad(req_size, req_addr[1:0]);
    assign resp_valid     = (state == RESP);
    assign mem_write_en   = (state == WR);
    assign mem_address    = r_addr[17:2];
    assign mem_write_data = (r_size == SIZE_W) ? r_wdata : merge_data;

    mem_lane_align u_lane (
        .rd_word     (mem_read_data),
        .base_word   (word_q),
        .size        (r_size),
        .offset      (r_addr[1:0]),
        .is_unsigned (r_unsigned),
        .wdata       (r_wdata),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: errors skip memory, sub-word stores read before writing.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)                                  state_nxt = RESP;
                    else if (!req_write || (req_size != SIZE_W)) state_nxt = RD;
                    else                                          state_nxt = WR;
                end
            end
            RD:      state_nxt = r_write ? WR : RESP;
            WR:      state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, read-word capture and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            word_q     <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                r_write    <= req_write;
                r_unsigned <= req_unsigned;
                r_size     <= req_size;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                resp_rdata <= '0;
                resp_err   <= req_err;
            end
            if (state == RD) begin
                word_q <= mem_read_data;
                if (!r_write) resp_rdata <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vectors plus random
// requests compared against a byte-arithmetic reference memory.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [17:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [15:0] mem_address;
    logic        mem_write_en;
    logic [31:0] mem_write_data, mem_read_data;

    int tests = 0;
    int fails = 0;
    int wr_count = 0;

    logic [31:0] mem     [int unsigned];
    logic [31:0] ref_mem [int unsigned];

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_address    (mem_address),
        .mem_write_en   (mem_write_en),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    function automatic logic [31:0] mem_rd(input int unsigned idx);
        return mem.exists(idx) ? mem[idx] : idx;
    endfunction

    function automatic logic [31:0] ref_rd(input int unsigned idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : idx;
    endfunction

    // Data memory: word i preloaded with i, write sampled on the clock edge.
    always @(posedge clk) begin
        if (mem_write_en) begin
            mem[32'(mem_address)] = mem_write_data;
            wr_count++;
        end
    end

    // Read port refreshed mid-cycle; the address only changes on rising edges.
    always @(negedge clk) mem_read_data = mem_rd(32'(mem_address));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [17:0] a, input logic [31:0] wd, input int hold,
                           output logic [31:0] rdata_o);
        logic              exp_err;
        logic [31:0]       exp_rd;
        int                exp_lat, lat, w0, nbytes, sh;
        longint unsigned   mask, w, v;
        int unsigned       idx;
        logic [31:0]       held;

        exp_err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        exp_rd  = '0;
        exp_lat = 1;
        if (!exp_err) begin
            nbytes = 1 << sz;
            idx    = 32'(a[17:2]);
            sh     = 8 * int'(a[1:0]);
            mask   = (64'd1 << (8 * nbytes)) - 64'd1;
            w      = 64'(ref_rd(idx));
            if (!wr) begin
                v = (w >> sh) & mask;
                if (!uns && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
                exp_rd  = v[31:0];
                exp_lat = 2;
            end else begin
                v = (w & ~(mask << sh)) | ((64'(wd) & mask) << sh);
                ref_mem[idx] = v[31:0];
                exp_lat = (nbytes == 4) ? 2 : 3;
            end
        end

        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        w0 = wr_count;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("resp_rdata", resp_rdata, exp_rd);
        check("resp_err", 32'(resp_err), 32'(exp_err));
        check("mem_address", 32'(mem_address), 32'(a[17:2]));
        held = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_rdata", resp_rdata, held);
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("req_ready_after", 32'(req_ready), 32'd1);
        check("resp_valid_after", 32'(resp_valid), 32'd0);
        check("write_count", 32'(wr_count - w0), 32'(!exp_err && wr));
        rdata_o = held;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        int          w0;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = '0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_mem_address", 32'(mem_address), 32'd0);
        check("rst_write_en", 32'(mem_write_en), 32'd0);
        rst = 1'b0;

        run_req(1'b0, 2'b10, 1'b0, 18'h014, 32'h0, 0, r);
        check("lw_014", r, 32'h00000005);

        run_req(1'b1, 2'b00, 1'b0, 18'h010, 32'h80, 0, r);
        run_req(1'b0, 2'b00, 1'b0, 18'h010, 32'h0, 0, r);
        check("lb_010", r, 32'hFFFFFF80);
        run_req(1'b0, 2'b00, 1'b1, 18'h010, 32'h0, 0, r);
        check("lbu_010", r, 32'h00000080);
        run_req(1'b0, 2'b10, 1'b0, 18'h010, 32'h0, 0, r);
        check("lw_010", r, 32'h00000080);

        run_req(1'b1, 2'b01, 1'b0, 18'h022, 32'hBEEF, 0, r);
        run_req(1'b0, 2'b10, 1'b0, 18'h020, 32'h0, 0, r);
        check("lw_020", r, 32'hBEEF0008);

        run_req(1'b1, 2'b01, 1'b0, 18'h011, 32'h1234, 0, r);
        run_req(1'b0, 2'b11, 1'b0, 18'h000, 32'h0, 0, r);

        run_req(1'b0, 2'b10, 1'b0, 18'h008, 32'h0, 3, r);
        check("lw_008_hold", r, 32'h00000002);

        // Reset while a sub-word store is in its read phase: no write may occur.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 18'h004; req_wdata = 32'hAA;
        w0 = wr_count;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rd_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rd_rst_req_ready", 32'(req_ready), 32'd1);
        check("rd_rst_rdata", resp_rdata, 32'd0);
        check("rd_rst_err", 32'(resp_err), 32'd0);
        check("rd_rst_mem_address", 32'(mem_address), 32'd0);
        check("rd_rst_writes", 32'(wr_count - w0), 32'd0);
        run_req(1'b0, 2'b10, 1'b0, 18'h004, 32'h0, 0, r);
        check("lw_004_after_rst", r, 32'h00000001);

        // Reset while a word store is writing: the write still lands.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 18'h030; req_wdata = 32'h12345678;
        w0 = wr_count;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ref_mem[32'd12] = 32'h12345678;
        check("wr_rst_writes", 32'(wr_count - w0), 32'd1);
        check("wr_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("wr_rst_write_en", 32'(mem_write_en), 32'd0);
        run_req(1'b0, 2'b10, 1'b0, 18'h030, 32'h0, 0, r);
        check("lw_030_after_rst", r, 32'h12345678);

        for (int n = 0; n < 60; n++) begin
            logic [17:0] a;
            a = ($urandom_range(0, 3) == 0) ? 18'($urandom) : 18'($urandom_range(0, 63));
            run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    a, $urandom, int'($urandom_range(0, 2)), r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port: req_valid  in  1  request present.
REQ-004 SHALL have port: req_ready  out  1  request accepted when req_valid and req_ready are both high at a clk edge.
REQ-005 SHALL have port: req_write  in  1  1 = store, 0 = load.
REQ-006 SHALL have port: req_size  in  2  00 byte, 01 half, 10 word; 11 illegal.
REQ-007 SHALL have port: req_unsigned  in  1  load zero-extend (1) or sign-extend (0); ignored for stores and words.
REQ-008 SHALL have port: req_addr  in  18  byte address.
REQ-009 SHALL have port: req_wdata  in  32  store data, right-justified.
REQ-010 SHALL have port: resp_valid  out  1  response present.
REQ-011 SHALL have port: resp_ready  in  1  response consumed when resp_valid and resp_ready are both high at a clk edge.
REQ-012 SHALL have port: resp_rdata  out  32  load result; 0 for stores and errors.
REQ-013 SHALL have port: resp_err  out  1  misaligned or illegal-size request.
REQ-014 SHALL have port: mem_address  out  16  word index to data memory (byte address bits 17:2).
REQ-015 SHALL have port: mem_write_en  out  1  word write strobe to data memory.
REQ-016 SHALL have port: mem_write_data  out  32  word written.
REQ-017 SHALL have port: mem_read_data  in  32  combinational read word from data memory.

Function
REQ-018 SHALL implement FSM states IDLE, RD, WR, RESP; req_ready = (state == IDLE).
REQ-019 On accept, SHALL register write, size, unsigned, addr and wdata, then transition:
- error -> RESP
- load or sub-word store -> RD
- word store -> WR
REQ-020 Error condition SHALL be: size 11, size 01 with addr[0] = 1, or size 10 with addr[1:0] != 0.
REQ-021 In RD, SHALL capture mem_read_data into a word register; next state is RESP for loads, WR for stores.
REQ-022 In WR, SHALL assert mem_write_en for exactly one cycle, then go to RESP. mem_write_data SHALL be:
- word store: registered wdata
- sub-word store: captured word with only the addressed byte/half lane replaced
REQ-023 Byte lanes SHALL be little-endian: offset 0 = bits 7:0, offset 3 = bits 31:24; half at offset 2 = bits 31:16.
REQ-024 Load result SHALL be the addressed lane, sign- or zero-extended to 32 bits per req_unsigned.
REQ-025 mem_address SHALL be driven from the registered address in all states; it is 0 after reset.
REQ-026 mem_write_en SHALL be 0 in every state except WR; no memory write SHALL occur on an error.
REQ-027 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_err SHALL hold stable until resp_ready, then the FSM returns to IDLE; there is no bypass back to back, so a new request is accepted no earlier than the cycle after the response handshake.
REQ-028 Latency from accept edge to resp_valid high SHALL be:
- load: 2 cycles
- word store: 2 cycles
- sub-word store: 3 cycles
- error: 1 cycle

Reset
REQ-029 rst SHALL force state IDLE, resp_valid 0, resp_rdata 0, resp_err 0 and all request registers 0 at the next clk edge, overriding any handshake.
REQ-030 Reset asserted while in WR SHALL NOT suppress that cycle's write (memory samples the same edge); the pending response is discarded.
REQ-031 Reset asserted in RD SHALL abort with no write.

Structure
REQ-032 A shared package SHALL hold the size encodings (SIZE_B, SIZE_H, SIZE_W) and the FSM state type.
REQ-033 Lane extract/extend and lane merge logic SHALL live in one combinational sub-module, mem_lane_align.

Verification (memory preloaded with word i = i)
REQ-034 LW addr 0x014 -> resp_rdata 0x00000005, resp_err 0, 2 cycles after accept.
REQ-035 SB 0x80 to 0x010, then LB 0x010 -> 0xFFFFFF80; LBU 0x010 -> 0x00000080; LW 0x010 -> 0x00000080 (upper lanes of the word 4 preserved as 0).
REQ-036 SH 0xBEEF to 0x022, then LW 0x020 -> 0xBEEF0008; mem_write_en high exactly one cycle.
REQ-037 SH to 0x011, and size 11 to 0x000 -> resp_err 1, resp_rdata 0, mem_write_en never high, 1-cycle latency.
REQ-038 LW 0x008 with resp_ready low 3 cycles -> resp_valid and rdata 0x00000002 held stable, req_ready 0 throughout; req_ready 1 the cycle after the handshake.
REQ-039 Reset asserted during RD of SB to 0x004 -> outputs at reset values next cycle; word 1 still reads 0x00000001.
